// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data wins.
module mem_port_arbiter #(
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic        mem_last,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_starve;
  logic          r_owner_d, r_we, r_if_ack, r_d_ack;
  logic [31:0]   r_addr, r_wdata, r_if_rdata, r_d_rdata;
  logic          w_if_elig, w_d_elig, w_grant, w_grant_d, w_done;

  // A requester is being acked this cycle, so its req still reflects the finished access.
  assign w_if_elig = if_req & ~r_if_ack;
  assign w_d_elig  = d_req & ~r_d_ack;
  assign w_grant   = (r_state == IDLE) & (w_if_elig | w_d_elig);
  assign w_grant_d = w_d_elig & (~w_if_elig | (r_starve < 4'(STARVE_MAX)));
  assign w_done    = (r_state == BUSY) & (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = BUSY;
      BUSY:    if (r_cnt == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_last = 1'b0;
    case (r_state)
      BUSY: begin
        mem_en   = 1'b1;
        mem_last = (r_cnt == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_starve   <= '0;
      r_owner_d  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      if (w_grant) begin
        r_owner_d <= w_grant_d;
        r_addr    <= w_grant_d ? d_addr : if_addr;
        r_we      <= w_grant_d & d_we;
        r_wdata   <= w_grant_d ? d_wdata : '0;
        r_cnt     <= CW'(LATENCY - 1);
        if (!w_grant_d)
          r_starve <= '0;
        else if (if_req && (r_starve < 4'(STARVE_MAX)))
          r_starve <= r_starve + 4'd1;
      end else if ((r_state == BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_done) begin
        if (r_owner_d) begin
          r_d_ack <= 1'b1;
          if (!r_we) r_d_rdata <= mem_rdata;
        end else begin
          r_if_ack   <= 1'b1;
          r_if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_we    = mem_en & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_stall  = if_req & ~r_if_ack;
  assign d_stall   = d_req & ~r_d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses LATENCY=2, instance 1 LATENCY=1, both STARVE_MAX=2.
// Directed table and sequences, then random requesters checked against a transaction-window model.
module tb_mem_port_arbiter;
  localparam int SM = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req[2], d_req[2], d_we[2], if_ack[2], if_stall[2], d_ack[2], d_stall[2];
  logic        mem_en[2], mem_we[2], mem_last[2];
  logic [31:0] if_addr[2], d_addr[2], d_wdata[2], if_rdata[2], d_rdata[2];
  logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2];

  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'h0050_0093 : (32'hA500_0000 | 32'(i));
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [31:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    always @(posedge clk)
      if (mem_en[k] && mem_we[k] && mem_last[k]) mem[mem_addr[k][7:2]] <= mem_wdata[k];
    assign mem_rdata[k] = mem[mem_addr[k][7:2]];

    mem_port_arbiter #(.LATENCY(k == 0 ? 2 : 1), .STARVE_MAX(SM)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[k]), .if_addr(if_addr[k]), .if_rdata(if_rdata[k]),
      .if_ack(if_ack[k]), .if_stall(if_stall[k]),
      .d_req(d_req[k]), .d_we(d_we[k]), .d_addr(d_addr[k]), .d_wdata(d_wdata[k]),
      .d_rdata(d_rdata[k]), .d_ack(d_ack[k]), .d_stall(d_stall[k]),
      .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_last(mem_last[k]),
      .mem_addr(mem_addr[k]), .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata[k]));
  end

  int checks, failures, cyc;

  // Reference model: each grant at cycle gt opens a window gt+1..gt+L, ack at gt+L+1.
  int          gt[2], ack_i[2], ack_d[2], starve[2];
  bit          own_d[2], g_we[2];
  logic [31:0] g_addr[2], g_wdata[2], e_ird[2], e_drd[2];
  logic [31:0] ref_mem[2][64];

  function automatic int lat(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic chk1(string nm, int k, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] cycle %0d: got %b expected %b", nm, k, cyc, act, exp);
    end
  endtask

  task automatic chk32(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] cycle %0d: got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic model_reset(int k);
    gt[k] = -100; ack_i[k] = -100; ack_d[k] = -100; starve[k] = 0;
    own_d[k] = 1'b0; g_we[k] = 1'b0; g_addr[k] = '0; g_wdata[k] = '0;
    e_ird[k] = '0; e_drd[k] = '0;
  endtask

  task automatic model_step(int k);
    int L;
    bit en, last, ie, de, gd;
    logic [5:0] idx;
    L    = lat(k);
    en   = (cyc > gt[k]) && (cyc <= gt[k] + L);
    last = (cyc == gt[k] + L);
    ie   = if_req[k] && (cyc != ack_i[k]);
    de   = d_req[k] && (cyc != ack_d[k]);
    chk1("mem_en", k, mem_en[k], en);
    chk1("mem_last", k, mem_last[k], last);
    chk1("mem_we", k, mem_we[k], en && g_we[k]);
    chk32("mem_addr", k, mem_addr[k], g_addr[k]);
    if (en && g_we[k]) chk32("mem_wdata", k, mem_wdata[k], g_wdata[k]);
    chk1("if_ack", k, if_ack[k], cyc == ack_i[k]);
    chk1("d_ack", k, d_ack[k], cyc == ack_d[k]);
    chk32("if_rdata", k, if_rdata[k], e_ird[k]);
    chk32("d_rdata", k, d_rdata[k], e_drd[k]);
    chk1("if_stall", k, if_stall[k], if_req[k] && (cyc != ack_i[k]));
    chk1("d_stall", k, d_stall[k], d_req[k] && (cyc != ack_d[k]));
    if (rst) begin
      model_reset(k);
      return;
    end
    if (last) begin
      idx = g_addr[k][7:2];
      if (own_d[k]) begin
        ack_d[k] = cyc + 1;
        if (g_we[k]) ref_mem[k][idx] = g_wdata[k];
        else         e_drd[k] = ref_mem[k][idx];
      end else begin
        ack_i[k] = cyc + 1;
        e_ird[k] = ref_mem[k][idx];
      end
    end
    if (!en && (ie || de)) begin
      gd = de && (!ie || starve[k] >= SM ? !ie : 1'b1);
      gd = de && (!ie || (starve[k] < SM));
      gt[k] = cyc;
      own_d[k] = gd;
      if (gd) begin
        g_addr[k] = d_addr[k]; g_we[k] = d_we[k]; g_wdata[k] = d_wdata[k];
        if (if_req[k]) starve[k] = (starve[k] < SM) ? starve[k] + 1 : SM;
      end else begin
        g_addr[k] = if_addr[k]; g_we[k] = 1'b0; g_wdata[k] = '0;
        starve[k] = 0;
      end
    end
  endtask

  task automatic adv();
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drv(int k, logic ir, logic [31:0] ia, logic dr, logic dw,
                     logic [31:0] da, logic [31:0] dd);
    if_req[k] = ir; if_addr[k] = ia;
    d_req[k] = dr; d_we[k] = dw; d_addr[k] = da; d_wdata[k] = dd;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] r;
    r = $urandom();
    return {r[31:8], 2'b00, r[5:2], 2'b00};
  endfunction

  task automatic req_gen(int k);
    bit igr, dgr;
    igr = !own_d[k] && (cyc <= gt[k] + lat(k));
    dgr = own_d[k] && (cyc <= gt[k] + lat(k));
    if (if_req[k]) begin
      if (if_ack[k]) begin
        if_req[k] = ($urandom_range(1, 0) == 1); if_addr[k] = rnd_addr();
      end else if (!igr && $urandom_range(7, 0) == 0) if_req[k] = 1'b0;
    end else if ($urandom_range(2, 0) == 0) begin
      if_req[k] = 1'b1; if_addr[k] = rnd_addr();
    end
    if (d_req[k]) begin
      if (d_ack[k]) begin
        d_req[k] = ($urandom_range(1, 0) == 1); d_addr[k] = rnd_addr();
        d_we[k] = ($urandom_range(1, 0) == 1); d_wdata[k] = $urandom();
      end else if (!dgr && $urandom_range(7, 0) == 0) d_req[k] = 1'b0;
    end else if ($urandom_range(2, 0) == 0) begin
      d_req[k] = 1'b1; d_addr[k] = rnd_addr();
      d_we[k] = ($urandom_range(1, 0) == 1); d_wdata[k] = $urandom();
    end
  endtask

  typedef struct {
    logic ireq, dreq, dwe;
    logic [31:0] dwd;
    logic en, last, we, iack, dack, istall, dstall;
    logic [31:0] ird, drd;
  } vec_t;

  vec_t tv[18];
  bit   st_i[16], st_d[16];

  localparam logic [31:0] F = 32'h0050_0093, D8 = 32'hA500_0008, W = 32'hDEAD_BEEF;

  initial begin
    // Fetch read, simultaneous fetch+data read, then a data write (instance 0, LATENCY=2).
    tv[0]  = '{1,0,0,0, 0,0,0,0,0,1,0, 0,0};
    tv[1]  = '{1,0,0,0, 1,0,0,0,0,1,0, 0,0};
    tv[2]  = '{1,0,0,0, 1,1,0,0,0,1,0, 0,0};
    tv[3]  = '{1,0,0,0, 0,0,0,1,0,0,0, F,0};
    tv[4]  = '{0,0,0,0, 0,0,0,0,0,0,0, F,0};
    tv[5]  = '{1,1,0,0, 0,0,0,0,0,1,1, F,0};
    tv[6]  = '{1,1,0,0, 1,0,0,0,0,1,1, F,0};
    tv[7]  = '{1,1,0,0, 1,1,0,0,0,1,1, F,0};
    tv[8]  = '{1,1,0,0, 0,0,0,0,1,1,0, F,D8};
    tv[9]  = '{1,0,0,0, 1,0,0,0,0,1,0, F,D8};
    tv[10] = '{1,0,0,0, 1,1,0,0,0,1,0, F,D8};
    tv[11] = '{1,0,0,0, 0,0,0,1,0,0,0, F,D8};
    tv[12] = '{0,0,0,0, 0,0,0,0,0,0,0, F,D8};
    tv[13] = '{0,1,1,W, 0,0,0,0,0,0,1, F,D8};
    tv[14] = '{0,1,1,W, 1,0,1,0,0,0,1, F,D8};
    tv[15] = '{0,1,1,W, 1,1,1,0,0,0,1, F,D8};
    tv[16] = '{0,1,1,W, 0,0,0,0,1,0,0, F,D8};
    tv[17] = '{0,0,0,0, 0,0,0,0,0,0,0, F,D8};
    st_i = '{1,0,0,0, 1,0,0,0, 1,1,1,1, 0,0,0,0};
    st_d = '{1,1,1,1, 1,1,1,1, 1,1,1,1, 1,1,1,0};

    checks = 0; failures = 0; cyc = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) ref_mem[k][i] = init_word(i);
      model_reset(k);
      drv(k, 0, 0, 0, 0, 0, 0);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk1("rst_mem_en", 0, mem_en[0], 1'b0);
    chk1("rst_mem_last", 0, mem_last[0], 1'b0);
    chk32("rst_mem_addr", 0, mem_addr[0], 32'h0);
    chk32("rst_mem_wdata", 0, mem_wdata[0], 32'h0);
    chk32("rst_if_rdata", 0, if_rdata[0], 32'h0);
    chk32("rst_d_rdata", 0, d_rdata[0], 32'h0);
    adv();
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drv(0, tv[i].ireq, 32'h10, tv[i].dreq, tv[i].dwe, 32'h20, tv[i].dwd);
      @(negedge clk);
      chk1("tv_mem_en", i, mem_en[0], tv[i].en);
      chk1("tv_mem_last", i, mem_last[0], tv[i].last);
      chk1("tv_mem_we", i, mem_we[0], tv[i].we);
      chk1("tv_if_ack", i, if_ack[0], tv[i].iack);
      chk1("tv_d_ack", i, d_ack[0], tv[i].dack);
      chk1("tv_if_stall", i, if_stall[0], tv[i].istall);
      chk1("tv_d_stall", i, d_stall[0], tv[i].dstall);
      chk32("tv_if_rdata", i, if_rdata[0], tv[i].ird);
      chk32("tv_d_rdata", i, d_rdata[0], tv[i].drd);
      adv();
    end
    chk32("write_commit", 0, g_dut[0].mem[8], W);

    // Reset lands in the middle of a write window.
    drv(0, 0, 0, 1, 1, 32'h24, 32'h1234_5678);
    @(negedge clk); adv();
    rst = 1'b1;
    @(negedge clk);
    chk1("rmw_busy", 0, mem_en[0], 1'b1);
    adv();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk1("rmw_mem_en", 0, mem_en[0], 1'b0);
    chk1("rmw_mem_last", 0, mem_last[0], 1'b0);
    chk1("rmw_d_ack", 0, d_ack[0], 1'b0);
    chk32("rmw_mem_addr", 0, mem_addr[0], 32'h0);
    chk32("rmw_mem_wdata", 0, mem_wdata[0], 32'h0);
    chk32("rmw_d_rdata", 0, d_rdata[0], 32'h0);
    chk32("rmw_if_rdata", 0, if_rdata[0], 32'h0);
    adv();
    @(negedge clk);
    chk1("rmw_no_ack", 0, d_ack[0], 1'b0);
    adv();
    chk32("rmw_no_commit", 0, g_dut[0].mem[9], init_word(9));

    // Fetch withdraws twice while data wins; the third contest must go to fetch.
    for (int s = 0; s < 16; s++) begin
      drv(0, st_i[s], 32'h10, st_d[s], 0, 32'h20, 0);
      @(negedge clk);
      if (s == 9)  chk32("starve_fetch_addr", 0, mem_addr[0], 32'h10);
      if (s == 11) chk1("starve_if_ack", 0, if_ack[0], 1'b1);
      if (s == 12) chk32("starve_data_addr", 0, mem_addr[0], 32'h20);
      if (s == 14) chk1("starve_d_ack", 0, d_ack[0], 1'b1);
      adv();
    end

    // LATENCY=1: both requesters held, grants alternate with one ack every two cycles.
    for (int c = 1; c <= 12; c++) begin
      if (c <= 10) drv(1, 1, 32'h10, 1, 0, 32'h20, 0);
      else         drv(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (c <= 10) begin
        chk1("l1_mem_en", 1, mem_en[1], (c % 2) == 0);
        chk1("l1_mem_last", 1, mem_last[1], (c % 2) == 0);
        chk1("l1_d_ack", 1, d_ack[1], (c % 4) == 3);
        chk1("l1_if_ack", 1, if_ack[1], (c % 4) == 1 && c > 1);
      end
      adv();
    end

    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) req_gen(k);
      @(negedge clk);
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
